embed_spi_slave: RTL and testbench

SPI slave (mode 3: CPOL=1, CPHA=1, MSB first) that answers the system's SPI master on a second board or a loopback header. It oversamples SCLK, SS_n and MOSI in the clk domain, shifts DATABITS-bit frames, and exposes rx/tx holding registers, status, control and irq on the same Avalon-style register map and bit layout as the team's SPI master. Sits on the CPU bus beside the master; status polling and irq handling are identical from firmware.

---
 rtl/embed_spi_pkg.sv | 25 ++
 rtl/embed_spi_sync.sv | 32 +++
 rtl/embed_spi_slave.sv | 210 +++++++++++++++++++++
 tb/tb_embed_spi_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/embed_spi_pkg.sv
// Shared SPI register map, status/control bit positions and FSM state type.
// Used by both the SPI slave and the SPI master rewrite.
package embed_spi_pkg;

   localparam logic [2:0] ADDR_RXDATA  = 3'd0;
   localparam logic [2:0] ADDR_TXDATA  = 3'd1;
   localparam logic [2:0] ADDR_STATUS  = 3'd2;
   localparam logic [2:0] ADDR_CONTROL = 3'd3;
   localparam logic [2:0] ADDR_EOPVAL  = 3'd6;

   // Control bits share the index of the status flag they enable.
   localparam int unsigned BIT_ROE  = 3;
   localparam int unsigned BIT_TOE  = 4;
   localparam int unsigned BIT_TMT  = 5;
   localparam int unsigned BIT_TRDY = 6;
   localparam int unsigned BIT_RRDY = 7;
   localparam int unsigned BIT_E    = 8;
   localparam int unsigned BIT_EOP  = 9;

   typedef enum logic {
      IDLE,
      ACTIVE
   } spi_state_t;

endpackage

// File: rtl/embed_spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall
// detection on the synchronized level.
module embed_spi_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_chain;
   logic                   r_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_chain <= {SYNC_STAGES{RST_VAL}};
         r_prev  <= RST_VAL;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
         r_prev  <= r_chain[SYNC_STAGES-1];
      end
   end

   assign o_sync = r_chain[SYNC_STAGES-1];
   assign o_rise = o_sync & ~r_prev;
   assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/embed_spi_slave.sv
// SPI mode-3 slave with the same CPU register map as the SPI master.
// Optional end-of-packet detection is built when EMBED_SPI_SLAVE_EOP_EN is defined.
module embed_spi_slave
   import embed_spi_pkg::*;
#(
   parameter int unsigned DATABITS    = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        spi_select,
   input  logic [2:0]  mem_addr,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [15:0] data_from_cpu,
   output logic [15:0] data_to_cpu,
   output logic        irq,
   input  logic        SCLK,
   input  logic        SS_n,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISO_oe
);

   localparam int unsigned CNT_W = (DATABITS > 1) ? $clog2(DATABITS) : 1;
`ifdef EMBED_SPI_SLAVE_EOP_EN
   localparam logic [15:0] CTRL_MASK = 16'h03D8;
`else
   localparam logic [15:0] CTRL_MASK = 16'h01D8;
`endif

   logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
   logic w_ss_sync, w_ss_rise, w_ss_fall;
   logic w_mosi_sync, w_mosi_rise, w_mosi_fall;

   embed_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
      .clk(clk), .reset_n(reset_n), .i_async(SCLK),
      .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
   embed_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .clk(clk), .reset_n(reset_n), .i_async(SS_n),
      .o_sync(w_ss_sync), .o_rise(w_ss_rise), .o_fall(w_ss_fall));
   embed_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (
      .clk(clk), .reset_n(reset_n), .i_async(MOSI),
      .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

   spi_state_t          r_state, w_state_nxt;
   logic                w_load;
   logic                r_reload_pend;
   logic                r_first;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic [DATABITS-1:0] r_tx_shift, r_tx_hold, r_rx_shift, r_rx_hold;
   logic                r_tx_primed;
   logic                r_rrdy, r_roe, r_toe;
   logic [15:0]         r_control;
   logic                r_rd_prev, r_wr_prev;
   logic                w_eop;
   logic [15:0]         w_status, w_rd_data;

   // Bus strobes fire once on the first cycle of each access.
   logic w_rd_stb, w_wr_stb, w_wr_tx, w_wr_status, w_rd_rx;
   assign w_rd_stb    = spi_select & ~read_n & ~r_rd_prev;
   assign w_wr_stb    = spi_select & ~write_n & ~r_wr_prev;
   assign w_wr_tx     = w_wr_stb & (mem_addr == ADDR_TXDATA);
   assign w_wr_status = w_wr_stb & (mem_addr == ADDR_STATUS);
   assign w_rd_rx     = w_rd_stb & (mem_addr == ADDR_RXDATA);

   logic w_run, w_lead, w_trail, w_last;
   assign w_run   = (r_state == ACTIVE) & ~w_ss_rise;
   assign w_lead  = w_run & w_sclk_fall;
   assign w_trail = w_run & w_sclk_rise;
   assign w_last  = w_trail & (r_bit_cnt == CNT_W'(DATABITS - 1));

   logic [DATABITS:0]   w_rx_ext;
   logic [DATABITS-1:0] w_rx_frame;
   assign w_rx_ext   = {r_rx_shift, w_mosi_sync};
   assign w_rx_frame = w_rx_ext[DATABITS-1:0];

   // A reload in the same cycle as a txdata write frees the holding register,
   // so the write is accepted even though tx_primed was set.
   logic w_tx_accept;
   assign w_tx_accept = w_wr_tx & (~r_tx_primed | w_load);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_ss_fall) begin
               w_state_nxt = ACTIVE;
               w_load      = 1'b1;
            end
         end
         ACTIVE: begin
            if (w_ss_rise)          w_state_nxt = IDLE;
            else if (r_reload_pend) w_load      = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tx_shift    <= '0;
         r_first       <= 1'b0;
         r_bit_cnt     <= '0;
         r_rx_shift    <= '0;
         r_rx_hold     <= '0;
         r_reload_pend <= 1'b0;
         r_tx_hold     <= '0;
         r_tx_primed   <= 1'b0;
      end else begin
         r_reload_pend <= w_last;
         if (w_load) begin
            r_tx_shift <= r_tx_primed ? r_tx_hold : '0;
            r_first    <= 1'b1;
         end else if (w_lead) begin
            if (r_first) r_first    <= 1'b0;
            else         r_tx_shift <= r_tx_shift << 1;
         end
         if (!w_run)       r_bit_cnt <= '0;
         else if (w_trail) r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
         if (w_trail) r_rx_shift <= w_rx_frame;
         if (w_last)  r_rx_hold  <= w_rx_frame;
         if (w_tx_accept) r_tx_hold <= data_from_cpu[DATABITS-1:0];
         if (w_tx_accept) r_tx_primed <= 1'b1;
         else if (w_load) r_tx_primed <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rrdy      <= 1'b0;
         r_roe       <= 1'b0;
         r_toe       <= 1'b0;
         r_control   <= '0;
         r_rd_prev   <= 1'b0;
         r_wr_prev   <= 1'b0;
         data_to_cpu <= '0;
         irq         <= 1'b0;
      end else begin
         r_rd_prev <= spi_select & ~read_n;
         r_wr_prev <= spi_select & ~write_n;
         if (w_last)       r_rrdy <= 1'b1;
         else if (w_rd_rx) r_rrdy <= 1'b0;
         if (w_last && r_rrdy) r_roe <= 1'b1;
         else if (w_wr_status) r_roe <= 1'b0;
         if (w_wr_tx && !w_tx_accept) r_toe <= 1'b1;
         else if (w_wr_status)        r_toe <= 1'b0;
         if (w_wr_stb && mem_addr == ADDR_CONTROL) r_control <= data_from_cpu & CTRL_MASK;
         if (w_rd_stb) data_to_cpu <= w_rd_data;
         irq <= |(w_status & r_control);
      end
   end

`ifdef EMBED_SPI_SLAVE_EOP_EN
   logic [15:0] r_eopval;
   logic        r_eop;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_eopval <= '0;
         r_eop    <= 1'b0;
      end else begin
         if (w_wr_stb && mem_addr == ADDR_EOPVAL) r_eopval <= data_from_cpu;
         if ((w_last && 16'(w_rx_frame) == r_eopval) || (w_wr_tx && data_from_cpu == r_eopval))
            r_eop <= 1'b1;
         else if (w_wr_status)
            r_eop <= 1'b0;
      end
   end
   assign w_eop = r_eop;
`else
   assign w_eop = 1'b0;
`endif

   always_comb begin
      w_status           = '0;
      w_status[BIT_ROE]  = r_roe;
      w_status[BIT_TOE]  = r_toe;
      w_status[BIT_TMT]  = (r_state == IDLE) & ~r_tx_primed;
      w_status[BIT_TRDY] = ~r_tx_primed;
      w_status[BIT_RRDY] = r_rrdy;
      w_status[BIT_E]    = r_roe | r_toe;
      w_status[BIT_EOP]  = w_eop;
   end

   always_comb begin
      w_rd_data = '0;
      case (mem_addr)
         ADDR_RXDATA:  w_rd_data = 16'(r_rx_hold);
         ADDR_STATUS:  w_rd_data = w_status;
         ADDR_CONTROL: w_rd_data = r_control;
`ifdef EMBED_SPI_SLAVE_EOP_EN
         ADDR_EOPVAL:  w_rd_data = r_eopval;
`endif
         default:      w_rd_data = '0;
      endcase
   end

   assign MISO    = r_tx_shift[DATABITS-1];
   assign MISO_oe = ~w_ss_sync;

   logic w_unused;
   assign w_unused = &{1'b0, w_sclk_sync, w_mosi_rise, w_mosi_fall, w_rx_ext[DATABITS], data_from_cpu};

endmodule

// File: tb/tb_embed_spi_slave.sv
// Bench for embed_spi_slave: drives a mode-3 SPI master and the CPU bus,
// scoreboarding expected MISO bits and received frames.
module tb_embed_spi_slave;
   import embed_spi_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        spi_select = 1'b0;
   logic [2:0]  mem_addr = '0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [15:0] data_from_cpu = '0;
   logic [15:0] data_to_cpu;
   logic        irq;
   logic        SCLK = 1'b1;
   logic        SS_n = 1'b1;
   logic        MOSI = 1'b1;
   logic        MISO;
   logic        MISO_oe;

   always #5 clk = ~clk;

   embed_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .mem_addr(mem_addr),
      .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
      .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK), .SS_n(SS_n),
      .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe));

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   logic [15:0] miso_q[$];
   logic [15:0] rx_q[$];
   logic        m_rrdy = 1'b0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
      repeat (2) @(negedge clk);
      spi_select = 1'b0; write_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
      @(negedge clk);
      spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
      repeat (2) @(negedge clk);
      spi_select = 1'b0; read_n = 1'b1;
      d = data_to_cpu;
   endtask

   task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
      logic [15:0] d;
      bus_read(a, d);
      check(tag, d, exp);
   endtask

   task automatic read_rx();
      logic [15:0] d;
      logic [15:0] exp;
      bus_read(ADDR_RXDATA, d);
      exp = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
      check("rxdata", d, exp);
      m_rrdy = 1'b0;
   endtask

   task automatic ss_low();
      @(negedge clk);
      SS_n = 1'b0;
      repeat (8) @(negedge clk);
      check("miso_oe_active", 16'(MISO_oe), 16'd1);
   endtask

   task automatic ss_high();
      repeat (8) @(negedge clk);
      SS_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Master side: drive MOSI on SCLK fall, sample MISO just before SCLK rise.
   task automatic spi_frame(input logic [7:0] mosi_val, input logic [7:0] miso_val,
                            input int unsigned nbits);
      logic [15:0] exp;
      for (int unsigned k = 0; k < nbits; k++) miso_q.push_back(16'(miso_val[7-k]));
      if (nbits == 8) begin
         if (m_rrdy && rx_q.size() > 0) void'(rx_q.pop_back());
         rx_q.push_back(16'(mosi_val));
         m_rrdy = 1'b1;
      end
      for (int unsigned k = 0; k < nbits; k++) begin
         @(negedge clk);
         SCLK = 1'b0;
         MOSI = mosi_val[7-k];
         repeat (8) @(negedge clk);
         exp = (miso_q.size() > 0) ? miso_q.pop_front() : 16'hDEAD;
         check("miso_bit", 16'(MISO), exp);
         SCLK = 1'b1;
         repeat (7) @(negedge clk);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (4) @(negedge clk);
      check("rst_data_to_cpu", data_to_cpu, 16'h0000);
      check("rst_irq", 16'(irq), 16'd0);
      check("rst_miso", 16'(MISO), 16'd0);
      check("rst_miso_oe", 16'(MISO_oe), 16'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      read_check("status_reset", ADDR_STATUS, 16'h0060);

      // Basic frame: tx 0xA5 out, rx 0x3C in
      bus_write(ADDR_TXDATA, 16'h00A5);
      read_check("status_primed", ADDR_STATUS, 16'h0000);
      ss_low();
      spi_frame(8'h3C, 8'hA5, 8);
      ss_high();
      check("miso_oe_idle", 16'(MISO_oe), 16'd0);
      read_check("status_rrdy", ADDR_STATUS, 16'h00E0);
      read_rx();
      read_check("status_after_rx", ADDR_STATUS, 16'h0060);

      // Two frames under one SS_n low, no tx: zeros out, overrun
      ss_low();
      spi_frame(8'h11, 8'h00, 8);
      spi_frame(8'h22, 8'h00, 8);
      ss_high();
      read_check("status_roe", ADDR_STATUS, 16'h01E8);
      read_rx();
      read_check("status_roe_rx", ADDR_STATUS, 16'h0168);
      check("irq_masked", 16'(irq), 16'd0);
      bus_write(ADDR_CONTROL, 16'h0100);
      check("irq_e", 16'(irq), 16'd1);
      read_check("control_rb", ADDR_CONTROL, 16'h0100);
      bus_write(ADDR_STATUS, 16'h0000);
      check("irq_cleared", 16'(irq), 16'd0);
      read_check("status_cleared", ADDR_STATUS, 16'h0060);
      bus_write(ADDR_CONTROL, 16'h0000);

      // Double tx write: TOE, first value kept and sent
      bus_write(ADDR_TXDATA, 16'h005A);
      bus_write(ADDR_TXDATA, 16'h00C3);
      read_check("status_toe", ADDR_STATUS, 16'h0110);
      bus_write(ADDR_STATUS, 16'h0000);
      read_check("status_toe_clr", ADDR_STATUS, 16'h0000);
      ss_low();
      spi_frame(8'h96, 8'h5A, 8);
      ss_high();
      read_rx();
      read_check("status_after_toe", ADDR_STATUS, 16'h0060);

      // Aborted 5-bit frame, then an aligned full frame
      ss_low();
      spi_frame(8'hFF, 8'h00, 5);
      ss_high();
      read_check("status_abort", ADDR_STATUS, 16'h0060);
      bus_write(ADDR_TXDATA, 16'h0081);
      ss_low();
      spi_frame(8'h6B, 8'h81, 8);
      ss_high();
      read_rx();

      // RRDY interrupt
      bus_write(ADDR_CONTROL, 16'h0080);
      check("irq_rrdy_idle", 16'(irq), 16'd0);
      ss_low();
      spi_frame(8'h42, 8'h00, 8);
      ss_high();
      check("irq_rrdy", 16'(irq), 16'd1);
      read_rx();
      @(negedge clk);
      check("irq_rrdy_clr", 16'(irq), 16'd0);
      bus_write(ADDR_CONTROL, 16'h0000);

      read_check("addr4_zero", 3'd4, 16'h0000);
`ifdef EMBED_SPI_SLAVE_EOP_EN
      bus_write(ADDR_EOPVAL, 16'h007E);
      read_check("eopval_rb", ADDR_EOPVAL, 16'h007E);
      ss_low();
      spi_frame(8'h7E, 8'h00, 8);
      ss_high();
      read_rx();
      read_check("status_eop", ADDR_STATUS, 16'h0260);
      bus_write(ADDR_STATUS, 16'h0000);
      read_check("status_eop_clr", ADDR_STATUS, 16'h0060);
`else
      bus_write(ADDR_EOPVAL, 16'h007E);
      read_check("addr6_zero", ADDR_EOPVAL, 16'h0000);
      ss_low();
      spi_frame(8'h7E, 8'h00, 8);
      ss_high();
      read_rx();
      read_check("status_no_eop", ADDR_STATUS, 16'h0060);
`endif
      check("sb_left", 16'(miso_q.size() + rx_q.size()), 16'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
